dvp_rgb565_capture: RTL and testbench
=====================================

# dvp_rgb565_capture

Single-frame DVP camera receiver and the consumer end of the RGB565 DVP stream. It is clocked by the camera pixel clock and locks to a frame boundary on VSYNC. It assembles byte pairs into 16-bit r[4:0]g[5:0]b[4:0] pixels with X/Y coordinates, and raises `frame_rdy` after one complete frame. It sits between the camera (or the pattern-generator dummy) and the SDRAM write path.

## Interface
Parameters:
- `VSYNC_ACTIVE_HIGH`, default 1: VSYNC polarity. 1 means a high level marks vertical blanking.

Ports:
- `capture_clk`  in  1  camera PCLK; all logic samples on its rising edge
- `capture_reset_n`  in  1  reset, asynchronous, active-low
- `capture_enable`  in  1  clock qualifier; low freezes all state and outputs
- `capture_start`  in  1  one-cycle pulse that arms a single-frame capture
- `horizontal_resolution`  in  13  pixels per line (up to 8191)
- `vertical_resolution`  in  12  lines per frame (up to 4095)
- `dvp_vsync`  in  1  camera VSYNC
- `dvp_href`  in  1  camera HREF, high while line bytes are valid
- `dvp_data`  in  8  camera byte bus
- `pixel_data`  out  16  assembled RGB565 pixel
- `pixel_valid`  out  1  one-cycle strobe qualifying `pixel_data`, `pixel_x` and `pixel_y`
- `pixel_x`  out  13  column of the current pixel
- `pixel_y`  out  12  row of the current pixel
- `frame_rdy`  out  1  high from frame completion until the next `capture_start`
- `frame_error`  out  3  sticky error flags: [0] odd byte count in a line, [1] line length mismatch, [2] short frame
- `capture_busy`  out  1  high in every state except IDLE and DONE

## Operation
- In this spec, "VSYNC active" means `dvp_vsync == VSYNC_ACTIVE_HIGH`.
- States: IDLE, ARM, SYNC, CAPTURE, DONE.
  - IDLE: wait for `capture_start`.
  - ARM: wait for VSYNC active.
  - SYNC: wait for VSYNC inactive; this edge is the frame start.
  - CAPTURE: receive the frame.
  - DONE: `frame_rdy` = 1; hold until the next `capture_start`.
- `capture_start` has priority in every state:
  - Go to ARM, even from CAPTURE (abort).
  - Clear the X/Y counters, `frame_error`, `frame_rdy` and the byte phase.
  - Latch `horizontal_resolution` and `vertical_resolution`. Changes to these inputs after the latch are ignored until the next start.
- CAPTURE byte pairing:
  - While `dvp_href` = 1, bytes alternate: first byte → `pixel_data[15:8]`, second byte → `pixel_data[7:0]`.
  - After each second byte, `pixel_valid` pulses with the current X/Y.
  - X increments after every pixel.
  - Pixels with X ≥ the latched horizontal resolution are suppressed (no `pixel_valid`) and set `frame_error[1]`.
- Line end (`dvp_href` 1→0, sampled):
  - Odd byte phase → set `frame_error[0]`, drop the half pixel.
  - X ≠ latched horizontal resolution → set `frame_error[1]`.
  - Then X ← 0, byte phase ← 0, Y ← Y+1.
  - If Y+1 equals the latched vertical resolution → go to DONE.
- VSYNC active in CAPTURE before the last line ends → set `frame_error[2]`, go to DONE.
- `capture_enable` = 0: no sampling, no state change, and `pixel_valid` is forced to 0.
- `dvp_href` and `dvp_data` are ignored outside CAPTURE.

## Timing
- Reset values: `pixel_data` = 0, `pixel_valid` = 0, `pixel_x` = 0, `pixel_y` = 0, `frame_rdy` = 0, `frame_error` = 0, `capture_busy` = 0; state = IDLE.
- Reset mid-frame aborts immediately with no further output.
- Latency: `pixel_valid`, `pixel_data`, `pixel_x` and `pixel_y` are registered. They become visible one cycle after the edge that samples the second byte. `pixel_valid` is high for exactly one cycle per pixel.
- Back-to-back pixels produce `pixel_valid` every second enabled cycle.
- HREF deasserting on the same edge that would sample a byte: that byte is not captured.
- `frame_rdy` and the DONE transition:
  - Normal completion: `frame_rdy` rises on the same edge as the last-line HREF-fall detection.
  - Short-frame abort: `frame_rdy` rises on the same edge as the VSYNC-active detection.
- `capture_start` coinciding with a pixel completion: the start wins and no `pixel_valid` is produced.
- Counters do not wrap within a frame. Y stops at the latched vertical resolution. X saturates at 8191 and sets `frame_error[1]`.

## Test plan
- **Normal frame.** Resolution 8×4; send VSYNC pulse, then 4 lines of 16 bytes with byte pairs 0xF8,0x00 → 32 `pixel_valid` pulses with `pixel_data` = 0xF800, X 0..7, Y 0..3; `frame_rdy` = 1; `frame_error` = 0.
- **Mid-frame arm.** `capture_start` issued mid-frame (VSYNC inactive, HREF toggling) → no `pixel_valid` until the next VSYNC active→inactive; then the full frame is captured.
- **Odd byte count.** Line of 15 bytes → 7 pixels in that line; `frame_error[0]` = 1 and `[1]` = 1; the next line starts at X = 0.
- **Long line.** Line of 20 bytes at width 8 → only 8 `pixel_valid` pulses; `frame_error[1]` = 1.
- **Short frame.** VSYNC active after 2 of 4 lines → DONE; `frame_rdy` = 1; `frame_error` = 3'b100.
- **Enable, abort and reset.** `capture_enable` low for 5 cycles mid-line → no pixels lost or duplicated once re-enabled. `capture_start` in DONE → `frame_rdy` = 0 the next cycle. `capture_reset_n` low mid-line → all outputs 0 asynchronously.

Source files
------------

// File: rtl/dvp_rgb565_capture.sv
// Single-frame DVP receiver: locks to a VSYNC active->inactive edge, pairs HREF-qualified
// bytes into RGB565 pixels with X/Y, and flags line/frame shape errors.
module dvp_rgb565_capture #(
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic        capture_clk,
    input  logic        capture_reset_n,
    input  logic        capture_enable,
    input  logic        capture_start,
    input  logic [12:0] horizontal_resolution,
    input  logic [11:0] vertical_resolution,
    input  logic        dvp_vsync,
    input  logic        dvp_href,
    input  logic [7:0]  dvp_data,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [12:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_rdy,
    output logic [2:0]  frame_error,
    output logic        capture_busy
);
    typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

    state_t      state;
    logic [12:0] hres, x;
    logic [11:0] vres, y;
    logic [7:0]  hi_byte;
    logic        phase, href_d;

    logic        vsync_act, last_line, x_in_range;
    logic [12:0] y_next, x_next;

    assign vsync_act  = (dvp_vsync == VSYNC_ACTIVE_HIGH);
    assign y_next     = {1'b0, y} + 13'd1;
    assign last_line  = (y_next >= {1'b0, vres});
    assign x_in_range = (x < hres);
    // X saturates rather than wrapping so an over-long line can never alias back into range
    assign x_next     = (x == 13'h1FFF) ? x : x + 13'd1;

    always_ff @(posedge capture_clk or negedge capture_reset_n) begin
        if (!capture_reset_n) begin
            state        <= IDLE;
            hres         <= '0;
            vres         <= '0;
            x            <= '0;
            y            <= '0;
            hi_byte      <= '0;
            phase        <= 1'b0;
            href_d       <= 1'b0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            frame_rdy    <= 1'b0;
            frame_error  <= '0;
            capture_busy <= 1'b0;
        end else if (!capture_enable) begin
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (capture_start) begin
                state        <= ARM;
                capture_busy <= 1'b1;
                x            <= '0;
                y            <= '0;
                phase        <= 1'b0;
                href_d       <= 1'b0;
                frame_error  <= '0;
                frame_rdy    <= 1'b0;
                hres         <= horizontal_resolution;
                vres         <= vertical_resolution;
            end else begin
                case (state)
                    ARM:  if (vsync_act) state <= SYNC;
                    SYNC: if (!vsync_act) begin
                        state  <= CAPTURE;
                        href_d <= 1'b0;
                    end
                    CAPTURE: begin
                        href_d <= dvp_href;
                        if (vsync_act) begin
                            // VSYNC before the last line closed: short frame
                            frame_error[2] <= 1'b1;
                            frame_rdy      <= 1'b1;
                            capture_busy   <= 1'b0;
                            state          <= DONE;
                        end else if (dvp_href) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi_byte <= dvp_data;
                            end else begin
                                x <= x_next;
                                if (x_in_range) begin
                                    pixel_valid <= 1'b1;
                                    pixel_data  <= {hi_byte, dvp_data};
                                    pixel_x     <= x;
                                    pixel_y     <= y;
                                end else begin
                                    frame_error[1] <= 1'b1;
                                end
                            end
                        end else if (href_d) begin
                            if (phase)     frame_error[0] <= 1'b1;
                            if (x != hres) frame_error[1] <= 1'b1;
                            x     <= '0;
                            phase <= 1'b0;
                            y     <= y_next[11:0];
                            if (last_line) begin
                                state        <= DONE;
                                frame_rdy    <= 1'b1;
                                capture_busy <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Randomized bench for dvp_rgb565_capture: a per-line byte model predicts pixels and
// error flags; a negedge monitor checks every pixel_valid against the expected queue.
module tb_dvp_rgb565_capture;
    logic        capture_clk = 1'b0;
    logic        capture_reset_n = 1'b1;
    logic        capture_enable = 1'b1;
    logic        capture_start = 1'b0;
    logic [12:0] horizontal_resolution = '0;
    logic [11:0] vertical_resolution = '0;
    logic        dvp_vsync = 1'b0;
    logic        dvp_href = 1'b0;
    logic [7:0]  dvp_data = '0;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic [12:0] pixel_x;
    logic [11:0] pixel_y;
    logic        frame_rdy;
    logic [2:0]  frame_error;
    logic        capture_busy;

    dvp_rgb565_capture dut (
        .capture_clk(capture_clk), .capture_reset_n(capture_reset_n),
        .capture_enable(capture_enable), .capture_start(capture_start),
        .horizontal_resolution(horizontal_resolution), .vertical_resolution(vertical_resolution),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_rdy(frame_rdy), .frame_error(frame_error), .capture_busy(capture_busy)
    );

    always #5 capture_clk = ~capture_clk;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
    } pix_t;

    pix_t     exp_q[$];
    pix_t     mon_e;
    int       n_cmp = 0, n_err = 0, pix_count = 0;
    int       last_x = -1, last_y = -1;
    logic     prev_valid = 1'b0;
    logic [2:0] exp_err;
    int       line_len[16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Every pixel strobe must match the head of the expected queue and never repeat back-to-back.
    always @(negedge capture_clk) begin
        if (capture_reset_n && pixel_valid) begin
            n_cmp++;
            pix_count++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel_unexpected: got data=%h x=%0d y=%0d, none expected",
                         pixel_data, pixel_x, pixel_y);
            end else begin
                mon_e = exp_q.pop_front();
                if (pixel_data !== mon_e.d || pixel_x !== 13'(mon_e.x) ||
                    pixel_y !== 12'(mon_e.y) || prev_valid) begin
                    n_err++;
                    $display("FAIL pixel: got data=%h x=%0d y=%0d repeat=%0b, want data=%h x=%0d y=%0d",
                             pixel_data, pixel_x, pixel_y, prev_valid, mon_e.d, mon_e.x, mon_e.y);
                end
                last_x = int'(pixel_x);
                last_y = int'(pixel_y);
            end
        end
        prev_valid = capture_reset_n && pixel_valid;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        dvp_data = b;
        dvp_href = 1'b1;
        if (gaps && $urandom_range(0, 2) == 0) begin
            capture_enable = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge capture_clk);
            capture_enable = 1'b1;
        end
        @(negedge capture_clk);
    endtask

    task automatic send_line(input int len, input int h, input int yy, input bit fixed, input bit gaps);
        logic [7:0] b[$];
        for (int i = 0; i < len; i++) b.push_back(fixed ? ((i % 2) ? 8'h00 : 8'hF8) : 8'($urandom));
        for (int j = 0; j < len / 2; j++)
            if (j < h) exp_q.push_back(pix_t'{d: {b[2*j], b[2*j+1]}, x: j, y: yy});
        if (len % 2) exp_err[0] = 1'b1;
        if (len / 2 != h) exp_err[1] = 1'b1;
        for (int i = 0; i < len; i++) send_byte(b[i], gaps);
        dvp_href = 1'b0;
        repeat ($urandom_range(2, 5)) begin
            dvp_data = 8'($urandom);
            @(negedge capture_clk);
        end
    endtask

    // Start pulse, junk traffic while armed mid-frame, then a VSYNC pulse to lock on.
    task automatic start_and_sync(input int h, input int v);
        exp_err = 3'b000;
        horizontal_resolution = 13'(h);
        vertical_resolution   = 12'(v);
        capture_start = 1'b1;
        @(negedge capture_clk);
        capture_start = 1'b0;
        horizontal_resolution = 13'($urandom);
        vertical_resolution   = 12'($urandom);
        check("busy_after_start", capture_busy, 1);
        repeat (20) begin
            dvp_href = 1'($urandom);
            dvp_data = 8'($urandom);
            @(negedge capture_clk);
        end
        dvp_href  = 1'b0;
        dvp_vsync = 1'b1;
        repeat (3) @(negedge capture_clk);
        dvp_vsync = 1'b0;
        repeat (3) @(negedge capture_clk);
    endtask

    task automatic run_frame(input int h, input int v, input int nl, input bit short_f,
                             input bit fixed, input bit gaps);
        start_and_sync(h, v);
        for (int l = 0; l < nl; l++) send_line(line_len[l], h, l, fixed, gaps);
        if (short_f) begin
            dvp_vsync  = 1'b1;
            exp_err[2] = 1'b1;
        end
        repeat (3) @(negedge capture_clk);
        check("frame_rdy", frame_rdy, 1);
        check("frame_error", frame_error, exp_err);
        check("busy_done", capture_busy, 0);
        check("queue_drained", exp_q.size(), 0);
        dvp_vsync = 1'b0;
    endtask

    initial begin
        int pc0, h, v, nl;
        bit sh;
        logic [7:0] rb[4];
        #1 capture_reset_n = 1'b0;
        #2;
        check("rst_pixel_data", pixel_data, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_pixel_y", pixel_y, 0);
        check("rst_frame_rdy", frame_rdy, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_busy", capture_busy, 0);
        repeat (3) @(negedge capture_clk);
        capture_reset_n = 1'b1;
        repeat (2) @(negedge capture_clk);

        // Normal 8x4 frame of 0xF800 pixels
        for (int i = 0; i < 4; i++) line_len[i] = 16;
        pc0 = pix_count;
        run_frame(8, 4, 4, 0, 1, 0);
        check("normal_count", pix_count - pc0, 32);
        check("normal_last_x", last_x, 7);
        check("normal_last_y", last_y, 3);
        check("normal_err_lit", frame_error, 3'b000);

        // Start while DONE drops frame_rdy on the next cycle
        capture_start = 1'b1;
        @(negedge capture_clk);
        capture_start = 1'b0;
        check("rdy_cleared", frame_rdy, 0);

        // Odd byte count on line 1
        line_len[0] = 16; line_len[1] = 15; line_len[2] = 16; line_len[3] = 16;
        pc0 = pix_count;
        run_frame(8, 4, 4, 0, 0, 0);
        check("odd_count", pix_count - pc0, 31);
        check("odd_err_lit", frame_error, 3'b011);

        // Long line at width 8
        line_len[0] = 16; line_len[1] = 20; line_len[2] = 16;
        pc0 = pix_count;
        run_frame(8, 3, 3, 0, 0, 0);
        check("long_count", pix_count - pc0, 24);
        check("long_err_lit", frame_error, 3'b010);

        // Short frame: VSYNC after 2 of 4 lines
        line_len[0] = 16; line_len[1] = 16;
        run_frame(8, 4, 2, 1, 0, 0);
        check("short_err_lit", frame_error, 3'b100);

        // Enable gaps inside lines
        for (int i = 0; i < 3; i++) line_len[i] = 12;
        pc0 = pix_count;
        run_frame(6, 3, 3, 0, 0, 1);
        check("gap_count", pix_count - pc0, 18);

        // Abort: start coincides with the edge that would complete a pixel
        start_and_sync(4, 4);
        send_line(8, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
        exp_q.push_back(pix_t'{d: {rb[0], rb[1]}, x: 0, y: 1});
        for (int i = 0; i < 3; i++) send_byte(rb[i], 0);
        dvp_data = rb[3];
        capture_start = 1'b1;
        @(negedge capture_clk);
        capture_start = 1'b0;
        dvp_href = 1'b0;
        check("abort_busy", capture_busy, 1);
        check("abort_err_clr", frame_error, 0);
        repeat (4) @(negedge capture_clk);
        check("abort_queue", exp_q.size(), 0);

        // Asynchronous reset mid-line
        start_and_sync(4, 4);
        for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
        exp_q.push_back(pix_t'{d: {rb[0], rb[1]}, x: 0, y: 0});
        exp_q.push_back(pix_t'{d: {rb[2], rb[3]}, x: 1, y: 0});
        for (int i = 0; i < 4; i++) send_byte(rb[i], 0);
        send_byte(8'h5A, 0);
        #2 capture_reset_n = 1'b0;
        #1;
        check("mid_rst_outputs", {pixel_data, pixel_valid, pixel_x, pixel_y, frame_rdy,
                                  frame_error, capture_busy} != '0, 0);
        check("mid_rst_queue", exp_q.size(), 0);
        @(negedge capture_clk);
        dvp_href = 1'b0;
        repeat (2) @(negedge capture_clk);
        capture_reset_n = 1'b1;
        repeat (4) @(negedge capture_clk);
        check("post_rst_idle", {capture_busy, frame_rdy, pixel_valid}, 0);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            h  = $urandom_range(1, 10);
            v  = $urandom_range(1, 4);
            sh = (v > 1) && ($urandom_range(0, 3) == 0);
            nl = sh ? $urandom_range(0, v - 1) : v;
            for (int l = 0; l < nl; l++)
                line_len[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * h + 4) : 2 * h;
            run_frame(h, v, nl, sh, 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
